// File: rtl/vga_sync_monitor_if.sv
// Sync stream under test together with the timing recovered from it.
// Latency: none, signal bundle only.
// Backpressure: none; the sync stream free-runs and results are level/pulse outputs.
interface vga_sync_monitor_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        p_tick_in;
  logic        locked;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        frame_start;
  logic [10:0] line_len;
  logic [10:0] frame_lines;
  logic [7:0]  err_cnt;

  // Source of the sync stream; observes the monitor results.
  modport master (
    output hsync_in, vsync_in, p_tick_in,
    input  locked, x, y, video_on, frame_start, line_len, frame_lines, err_cnt
  );

  // The monitor itself.
  modport slave (
    input  hsync_in, vsync_in, p_tick_in,
    output locked, x, y, video_on, frame_start, line_len, frame_lines, err_cnt
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Measures an incoming hsync/vsync/tick stream, recovers x/y and locks onto nominal timing.
// Latency: 2-FF input sync plus one registered stage, outputs follow an input edge by 3 clocks.
// Backpressure: none; every tick and sync edge is consumed as it arrives.
module vga_sync_monitor #(
  parameter int H_TOTAL          = 800,
  parameter int V_TOTAL          = 525,
  parameter int H_DISPLAY        = 640,
  parameter int V_DISPLAY        = 480,
  parameter int H_SYNC_START     = 656,
  parameter int V_SYNC_START     = 490,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int LOCK_FRAMES      = 2
) (
  input logic               clk_50MHz,
  input logic               reset,
  vga_sync_monitor_if.slave mon
);
  localparam logic        SYNC_INV  = (SYNC_ACTIVE_HIGH == 0);
  localparam logic [10:0] H_TOT     = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT     = 11'(V_TOTAL);
  localparam logic [10:0] WD_LAST   = 11'(2 * H_TOTAL - 1);
  localparam logic [9:0]  X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  X_SYNC    = 10'(H_SYNC_START);
  localparam logic [9:0]  Y_SYNC    = 10'(V_SYNC_START);
  localparam logic [9:0]  X_DISP    = 10'(H_DISPLAY);
  localparam logic [9:0]  Y_DISP    = 10'(V_DISPLAY);
  localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t state, state_nxt;

  // Bit order {hsync, vsync, tick}; syncs are polarity-normalised before the
  // synchronizer so that a reset value of 0 always means "inactive".
  logic [2:0]  sync_a, sync_b;
  logic        hs_prev, vs_prev;
  logic        hs_edge, vs_edge, tick;
  logic [10:0] tick_cnt, line_cnt, line_len_r, frame_lines_r;
  logic        line_armed, frame_armed;
  logic [7:0]  good_cnt, good_cnt_nxt, good_inc, err_cnt_r;
  logic        line_err, frame_err, wd_err, err;
  logic [9:0]  x_r, y_r, x_nxt, y_nxt;
  logic        locked_r, video_on_r, frame_start_r;

  // Two-stage synchronizer for all three inputs plus previous-sample registers.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      sync_a  <= '0;
      sync_b  <= '0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      sync_a  <= {mon.hsync_in ^ SYNC_INV, mon.vsync_in ^ SYNC_INV, mon.p_tick_in};
      sync_b  <= sync_a;
      hs_prev <= sync_b[2];
      vs_prev <= sync_b[1];
    end
  end

  assign hs_edge = sync_b[2] & ~hs_prev;
  assign vs_edge = sync_b[1] & ~vs_prev;
  assign tick    = sync_b[0];

  // An edge always wins over a coincident tick, so a new line starts at 0.
  assign line_err  = hs_edge && line_armed && (tick_cnt != H_TOT);
  assign frame_err = vs_edge && frame_armed && (line_cnt != V_TOT);
  assign wd_err    = tick && !hs_edge && (tick_cnt == WD_LAST);
  assign err       = (state != SEARCH) && (line_err || frame_err || wd_err);
  assign good_inc  = good_cnt + 8'd1;

  // Line/frame length counters, checker arming and the error counter.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      tick_cnt      <= '0;
      line_cnt      <= '0;
      line_len_r    <= '0;
      frame_lines_r <= '0;
      line_armed    <= 1'b0;
      frame_armed   <= 1'b0;
      err_cnt_r     <= '0;
    end else begin
      if (hs_edge) begin
        line_len_r <= tick_cnt;
        tick_cnt   <= '0;
      end else if (tick && tick_cnt != 11'h7FF) begin
        tick_cnt <= tick_cnt + 11'd1;
      end
      if (vs_edge) begin
        frame_lines_r <= line_cnt;
        line_cnt      <= '0;
      end else if (hs_edge && line_cnt != 11'h7FF) begin
        line_cnt <= line_cnt + 11'd1;
      end
      if (state == SEARCH) begin
        line_armed  <= 1'b0;
        frame_armed <= 1'b0;
      end else begin
        if (hs_edge) line_armed <= 1'b1;
        if (vs_edge) frame_armed <= 1'b1;
      end
      if (err && err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  // Next-state and good-frame counting for the lock state machine.
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    case (state)
      SEARCH: begin
        if (vs_edge) begin
          state_nxt    = ACQUIRE;
          good_cnt_nxt = '0;
        end
      end
      ACQUIRE: begin
        if (err) begin
          state_nxt = SEARCH;
        end else if (vs_edge) begin
          good_cnt_nxt = good_inc;
          if (good_inc >= LOCK_N) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (err) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Coordinate recovery: sync edges re-anchor x/y, ticks advance them.
  always_comb begin
    x_nxt = x_r;
    y_nxt = y_r;
    if (hs_edge) begin
      x_nxt = X_SYNC;
    end else if (tick) begin
      if (x_r == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y_r == Y_LAST) ? '0 : y_r + 10'd1;
      end else begin
        x_nxt = x_r + 10'd1;
      end
    end
    if (vs_edge) y_nxt = Y_SYNC;
  end

  // State register and registered outputs.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state         <= SEARCH;
      good_cnt      <= '0;
      x_r           <= '0;
      y_r           <= '0;
      locked_r      <= 1'b0;
      video_on_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state         <= state_nxt;
      good_cnt      <= good_cnt_nxt;
      x_r           <= x_nxt;
      y_r           <= y_nxt;
      locked_r      <= (state_nxt == LOCKED);
      video_on_r    <= (state_nxt == LOCKED) && (x_nxt < X_DISP) && (y_nxt < Y_DISP);
      frame_start_r <= vs_edge;
    end
  end

  assign mon.locked      = locked_r;
  assign mon.x           = x_r;
  assign mon.y           = y_r;
  assign mon.video_on    = video_on_r;
  assign mon.frame_start = frame_start_r;
  assign mon.line_len    = line_len_r;
  assign mon.frame_lines = frame_lines_r;
  assign mon.err_cnt     = err_cnt_r;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down 20x12 timing.
// Latency: a driven sync edge shows on the outputs 3 clocks later.
// Backpressure: none; the bench free-runs a sync generator.
module tb_vga_sync_monitor;
  localparam int HT = 20, VT = 12, HD = 16, VD = 8;
  localparam int HSS = 17, VSS = 9, HW = 2, VW = 2;

  logic clk_50MHz;
  logic rst_n;
  logic hs, vs, tk;
  int   n_tests, n_fail;
  int   gx, gy, phase, vs_edges, hs_edges, ticks_since_hs;
  bit   short_line, short_frame, hs_kill;
  int   von, unl, guard;

  vga_sync_monitor_if if0 ();
  vga_sync_monitor_if if1 ();

  // dut1 sees the same stream with active-low syncs.
  assign if0.hsync_in  = hs;
  assign if0.vsync_in  = vs;
  assign if0.p_tick_in = tk;
  assign if1.hsync_in  = ~hs;
  assign if1.vsync_in  = ~vs;
  assign if1.p_tick_in = tk;

  vga_sync_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_DISPLAY(HD), .V_DISPLAY(VD),
    .H_SYNC_START(HSS), .V_SYNC_START(VSS), .SYNC_ACTIVE_HIGH(1), .LOCK_FRAMES(2))
    dut0 (.clk_50MHz(clk_50MHz), .reset(rst_n), .mon(if0));

  vga_sync_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_DISPLAY(HD), .V_DISPLAY(VD),
    .H_SYNC_START(HSS), .V_SYNC_START(VSS), .SYNC_ACTIVE_HIGH(0), .LOCK_FRAMES(2))
    dut1 (.clk_50MHz(clk_50MHz), .reset(rst_n), .mon(if1));

  initial begin
    clk_50MHz = 1'b0;
    forever #10 clk_50MHz = ~clk_50MHz;
  end

  initial begin
    #3000000;
    $display("FAIL tb_timeout: run still active, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_50MHz);
      #1;
    end
  endtask

  // One generator half-pixel: tick cycle advances x/y, next cycle updates the syncs.
  task automatic half();
    logic nh, nv;
    int lt, ft;
    @(posedge clk_50MHz);
    #1;
    if (phase == 0) begin
      tk = 1'b1;
      lt = short_line ? HT - 1 : HT;
      ft = short_frame ? VT - 1 : VT;
      if (gx >= lt - 1) begin
        gx = 0;
        short_line = 1'b0;
        if (gy >= ft - 1) begin
          gy = 0;
          short_frame = 1'b0;
        end else begin
          gy++;
        end
      end else begin
        gx++;
      end
      ticks_since_hs++;
      phase = 1;
    end else begin
      tk = 1'b0;
      nh = !hs_kill && gx >= HSS && gx < HSS + HW;
      nv = gy >= VSS && gy < VSS + VW;
      if (nh && !hs) begin
        hs_edges++;
        ticks_since_hs = 0;
      end
      if (nv && !vs) vs_edges++;
      hs = nh;
      vs = nv;
      phase = 0;
    end
  endtask

  task automatic run_to_vs(input int n, input string tag);
    int target;
    target = vs_edges + n;
    for (int i = 0; i < n * 4 * HT * VT + 64 && vs_edges < target; i++) half();
    if (vs_edges != target) check({tag, "_vs_wait"}, vs_edges, target);
  endtask

  task automatic run_to_hs(input int n, input string tag);
    int target;
    target = hs_edges + n;
    for (int i = 0; i < n * 4 * HT + 64 && hs_edges < target; i++) half();
    if (hs_edges != target) check({tag, "_hs_wait"}, hs_edges, target);
  endtask

  task automatic run_to_pos(input int py, input int px, input string tag);
    for (int i = 0; i < 4 * HT * VT && !(gy == py && gx == px && phase == 1); i++) half();
    if (!(gy == py && gx == px)) check({tag, "_pos_wait"}, gy * HT + gx, py * HT + px);
  endtask

  // Called right after the lock-completing vsync edge has been driven.
  task automatic lock_seq(input string tag);
    half();
    half();
    check({tag, "_early0"}, 32'(if0.locked), 0);
    check({tag, "_early1"}, 32'(if1.locked), 0);
    half();
    check({tag, "_lock0"}, 32'(if0.locked), 1);
    check({tag, "_lock1"}, 32'(if1.locked), 1);
    check({tag, "_fs"}, 32'(if0.frame_start), 1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; tk = 1'b0;
    gx = 0; gy = 3; phase = 0;
    vs_edges = 0; hs_edges = 0; ticks_since_hs = 0;
    short_line = 1'b0; short_frame = 1'b0; hs_kill = 1'b0;
    cyc(3);
    check("rst_locked", 32'(if0.locked), 0);
    check("rst_x", 32'(if0.x), 0);
    check("rst_y", 32'(if0.y), 0);
    check("rst_video_on", 32'(if0.video_on), 0);
    check("rst_frame_start", 32'(if0.frame_start), 0);
    check("rst_line_len", 32'(if0.line_len), 0);
    check("rst_frame_lines", 32'(if0.frame_lines), 0);
    check("rst_err_cnt", 32'(if0.err_cnt), 0);
    check("rst_locked_n", 32'(if1.locked), 0);
    rst_n = 1'b1;

    // Nominal stream from mid-frame: lock after the 3rd vsync edge.
    run_to_vs(3, "s1");
    lock_seq("s1");
    check("s1_x", 32'(if0.x), 0);
    check("s1_y", 32'(if0.y), VSS);
    check("s1_line_len", 32'(if0.line_len), HT);
    check("s1_frame_lines", 32'(if0.frame_lines), VT);
    check("s1_err_cnt", 32'(if0.err_cnt), 0);
    check("s1_line_len_n", 32'(if1.line_len), HT);
    von = 0; unl = 0; guard = 0;
    do begin
      von += int'(if0.video_on);
      unl += int'(!if0.locked);
      half();
      guard++;
    end while (if0.frame_start !== 1'b1 && guard < 4 * HT * VT);
    check("s1_frame_clks", guard, 2 * HT * VT);
    check("s1_video_clks", von, 2 * HD * VD);
    check("s1_unlocked_clks", unl, 0);

    // One short line while locked.
    run_to_pos(2, 0, "s2");
    short_line = 1'b1;
    run_to_hs(2, "s2");
    half();
    half();
    check("s2_still_locked", 32'(if0.locked), 1);
    half();
    check("s2_drop", 32'(if0.locked), 0);
    check("s2_err_cnt", 32'(if0.err_cnt), 1);
    check("s2_line_len", 32'(if0.line_len), HT - 1);
    run_to_vs(3, "s2r");
    lock_seq("s2r");

    // hsync held inactive: watchdog after 2*HT ticks.
    run_to_pos(1, 0, "s3");
    run_to_hs(1, "s3");
    hs_kill = 1'b1;
    for (int i = 0; i < 8 * HT && ticks_since_hs < 2 * HT; i++) half();
    if (ticks_since_hs != 2 * HT) check("s3_tick_wait", ticks_since_hs, 2 * HT);
    half();
    half();
    check("s3_still_locked", 32'(if0.locked), 1);
    half();
    check("s3_drop", 32'(if0.locked), 0);
    check("s3_video_off", 32'(if0.video_on), 0);
    check("s3_err_cnt", 32'(if0.err_cnt), 2);
    hs_kill = 1'b0;
    run_to_vs(3, "s3r");
    lock_seq("s3r");

    // One frame one line short.
    run_to_vs(1, "s4a");
    short_frame = 1'b1;
    run_to_vs(1, "s4b");
    half();
    half();
    check("s4_still_locked", 32'(if0.locked), 1);
    half();
    check("s4_frame_lines", 32'(if0.frame_lines), VT - 1);
    check("s4_drop", 32'(if0.locked), 0);
    check("s4_err_cnt", 32'(if0.err_cnt), 3);
    check("s4_fs", 32'(if0.frame_start), 1);
    run_to_vs(3, "s4r");
    lock_seq("s4r");

    // Asynchronous reset mid-frame, then relock.
    run_to_pos(3, 5, "s5");
    #3;
    rst_n = 1'b0;
    #1;
    check("s5_locked", 32'(if0.locked), 0);
    check("s5_x", 32'(if0.x), 0);
    check("s5_y", 32'(if0.y), 0);
    check("s5_line_len", 32'(if0.line_len), 0);
    check("s5_frame_lines", 32'(if0.frame_lines), 0);
    check("s5_err_cnt", 32'(if0.err_cnt), 0);
    check("s5_locked_n", 32'(if1.locked), 0);
    half();
    half();
    check("s5_held_locked", 32'(if0.locked), 0);
    rst_n = 1'b1;
    run_to_vs(3, "s5r");
    lock_seq("s5r");
    check("s5r_err_cnt", 32'(if0.err_cnt), 0);
    check("s5r_frame_lines", 32'(if0.frame_lines), VT);

    // Error counter saturation: 300 acquire-then-fail episodes.
    rst_n = 1'b0;
    hs = 1'b0; vs = 1'b0; tk = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    for (int i = 0; i < 300; i++) begin
      vs = 1'b1;
      cyc(2);
      vs = 1'b0;
      cyc(1);
      if (i == 0) check("s6_fs_search", 32'(if0.frame_start), 1);
      cyc(1);
      if (i == 0) check("s6_fs_pulse", 32'(if0.frame_start), 0);
      hs = 1'b1;
      cyc(2);
      hs = 1'b0;
      cyc(1);
      repeat (3) begin
        tk = 1'b1;
        cyc(1);
        tk = 1'b0;
        cyc(1);
      end
      hs = 1'b1;
      cyc(2);
      hs = 1'b0;
      cyc(4);
      if (i == 0) begin
        check("s6_err_first", 32'(if0.err_cnt), 1);
        check("s6_err_first_n", 32'(if1.err_cnt), 1);
        check("s6_line_len", 32'(if0.line_len), 3);
      end
      if (i == 253) check("s6_err_254", 32'(if0.err_cnt), 254);
      if (i == 254) check("s6_err_255", 32'(if0.err_cnt), 255);
    end
    check("s6_err_sat", 32'(if0.err_cnt), 255);
    check("s6_err_sat_n", 32'(if1.err_cnt), 255);
    check("s6_locked", 32'(if0.locked), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA sync generator.
- Samples hsync, vsync and the pixel tick, measures line and frame timing, and checks it against the 640x480 timing the generator produces.
- Recovers pixel coordinates from the sync edges and asserts `locked` once timing is stable.
- Used for loopback self-test of the display path and as the timing source for overlay logic driven from an external sync stream.

Parameters:
H_TOTAL, 800, pixel ticks per line
V_TOTAL, 525, lines per frame
H_DISPLAY, 640, active pixels per line
V_DISPLAY, 480, active lines per frame
H_SYNC_START, 656, x value loaded on a hsync leading edge
V_SYNC_START, 490, y value loaded on a vsync leading edge
SYNC_ACTIVE_HIGH, 1, 1: sync asserted = high; 0: asserted = low
LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
clk_50MHz  in  1  system clock
reset  in  1  asynchronous, active-low
hsync_in  in  1  horizontal sync under test
vsync_in  in  1  vertical sync under test
p_tick_in  in  1  pixel-enable tick, 1 cycle wide
locked  out  1  timing matches the parameters
x  out  10  recovered horizontal position
y  out  10  recovered vertical position
video_on  out  1  locked && x<H_DISPLAY && y<V_DISPLAY
frame_start  out  1  1-cycle pulse on each vsync leading edge
line_len  out  11  ticks counted in the last complete line
frame_lines  out  11  hsync edges counted in the last complete frame
err_cnt  out  8  timing errors, saturating

Behaviour:
- Reset (async, active-low): every register and output is 0; state is SEARCH.
- Input path:
  - hsync_in, vsync_in and p_tick_in each pass through a 2-FF synchronizer on clk_50MHz, so all three see identical latency.
  - Polarity is normalised by SYNC_ACTIVE_HIGH.
- Leading edge = normalised sync was inactive on the previous synchronized sample and is active now.
- Tick counter:
  - Increments on every synchronized tick.
  - On a hsync edge, line_len is updated with the count and the counter clears to 0.
  - If an edge and a tick fall in the same cycle, the edge wins and the counter clears to 0, not 1.
  - The counter is 11 bits and saturates at 2047.
- Line counter: increments on each hsync edge. On a vsync edge, frame_lines is updated and the counter clears to 0.
- Line check: line_len != H_TOTAL is an error.
  - Armed only after one hsync edge has been seen since entering ACQUIRE.
- Frame check: frame_lines != V_TOTAL is an error.
  - Armed only after one vsync edge has been seen since entering ACQUIRE.
- Watchdog: tick counter reaching 2*H_TOTAL without a hsync edge is an error. Applies in ACQUIRE and LOCKED.
- Coordinate recovery:
  - On a hsync edge, x loads H_SYNC_START.
  - Otherwise each tick increments x; x wraps H_TOTAL-1 -> 0, and on that wrap y increments, wrapping V_TOTAL-1 -> 0.
  - On a vsync edge, y loads V_SYNC_START; this takes priority over the wrap increment in the same cycle.
  - x and y run in every state but are meaningful only while locked.
- State machine:
  - SEARCH: locked=0. On a vsync edge -> ACQUIRE, with good_cnt=0 and the checks disarmed.
  - ACQUIRE:
    - On each vsync edge where the frame had no error, good_cnt++.
    - When good_cnt reaches LOCK_FRAMES -> LOCKED; locked rises in the cycle after that edge.
    - Any error -> SEARCH.
  - LOCKED: locked=1. Any error -> SEARCH; locked falls in the cycle after the error is detected.
- Errors:
  - Each error event increments err_cnt by exactly 1, even if several checks fail in the same cycle.
  - err_cnt saturates at 255.
  - Errors are not counted in SEARCH.
- frame_start pulses for every vsync edge, in every state, one cycle after the edge is detected.
- All outputs are registered. video_on is 0 whenever locked=0.

Test Plan:
- Nominal stream (800-tick lines, 96-tick hsync from x=656, 525 lines, 2-line vsync from y=490, ticks every 2nd clk), started mid-frame:
  - locked rises 1 clk after the 3rd vsync edge.
  - line_len=800, frame_lines=525, err_cnt=0.
  - Once locked, video_on is high for exactly 640x480 ticks per frame.
- Locked stream, then one line shortened to 799 ticks:
  - locked falls 1 clk after the next hsync edge, err_cnt=1, line_len=799.
  - locked re-asserts after 3 further good vsync edges.
- Locked stream, then hsync held inactive: error after 1600 ticks without an edge; locked=0, err_cnt+1, state SEARCH.
- Locked stream, then a frame of 524 lines: at the vsync edge, frame_lines=524, locked=0, err_cnt+1.
- Reset asserted mid-frame: all outputs 0 immediately (asynchronously); after release the monitor relocks per the first scenario.
- SYNC_ACTIVE_HIGH=0 with inverted syncs: same lock timing as the first scenario. 300 injected errors: err_cnt holds at 255.
